// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with a handshaked word memory port.
module data_cache #(
    parameter int SETS       = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [2:0]            AddressingControl,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  Stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2;

    logic [1:0]            state;
    logic [SETS-1:0]       valid;
    logic [TAG-1:0]        tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS];
    logic [IDX-1:0]        idx, midx;
    logic [TAG-1:0]        tag, mtag;
    logic                  hit, mhit, idle;
    logic [DATA_WIDTH-1:0] word, ext, st_wdata, merged;
    logic [7:0]            b;
    logic [15:0]           h;
    logic [3:0]            st_strb;

    assign idx  = A[IDX+1:2];
    assign tag  = A[31:IDX+2];
    // Fill and store-merge use the latched request address, not the live CPU address.
    assign midx = mem_addr[IDX+1:2];
    assign mtag = mem_addr[31:IDX+2];
    assign hit  = valid[idx] && tags[idx] == tag;
    assign mhit = valid[midx] && tags[midx] == mtag;
    assign idle = state == IDLE;
    assign word = data[idx];
    assign b    = word[{A[1:0], 3'b000} +: 8];
    assign h    = A[1] ? word[31:16] : word[15:0];

    always_comb begin
        ext = AddressingControl == 3'b000 ? {{24{b[7]}}, b} :
              AddressingControl == 3'b100 ? {24'b0, b} :
              AddressingControl == 3'b001 ? {{16{h[15]}}, h} :
              AddressingControl == 3'b101 ? {16'b0, h} : word;
        st_wdata = AddressingControl == 3'b000 ? {4{WD[7:0]}} :
                   AddressingControl == 3'b001 ? {2{WD[15:0]}} : WD;
        st_strb = AddressingControl == 3'b000 ? 4'b0001 << A[1:0] :
                  AddressingControl == 3'b001 ? (A[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        merged = data[midx];
        for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
        RD    = (rst && idle && RE && !WE && hit) ? ext : '0;
        Stall = rst && (idle ? (WE || (RE && !hit)) : (state == FILL || !mem_ack));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush) valid <= '0;
                    if (WE) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {A[31:2], 2'b00};
                        mem_wdata <= st_wdata;
                        mem_wstrb <= st_strb;
                    end else if (RE && hit) begin
                        HitCount <= HitCount + 32'd1;
                    end else if (RE) begin
                        state     <= FILL;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {A[31:2], 2'b00};
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        MissCount <= MissCount + 32'd1;
                    end
                end
                FILL: if (mem_ack) begin
                    state       <= IDLE;
                    mem_req     <= 1'b0;
                    valid[midx] <= 1'b1;
                end
                WRITE: if (mem_ack) begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits alone gate every hit.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data[midx] <= mem_rdata;
            tags[midx] <= mtag;
        end else if (state == WRITE && mem_ack && mhit) begin
            data[midx] <= merged;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized scoreboard bench for data_cache with a behavioural memory and residency model.
module tb_data_cache;
    localparam int SETS = 16;

    logic        clk, rst, WE, RE, Flush, Stall, mem_req, mem_we, mem_ack;
    logic [31:0] A, WD, RD, mem_addr, mem_wdata, mem_rdata, HitCount, MissCount;
    logic [2:0]  AddressingControl;
    logic [3:0]  mem_wstrb;

    data_cache #(.SETS(SETS), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .AddressingControl(AddressingControl), .Flush(Flush), .RD(RD), .Stall(Stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } wr_t;

    int          total = 0, bad = 0;
    int          exp_hit, exp_miss, fixed_lat = -1, lat = -1, stalls;
    int          resident [SETS];
    logic [31:0] rd_q [$];
    wr_t         wr_q [$];
    logic [31:0] mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] init_word(logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_ref(logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ld_val(logic [31:0] a, logic [2:0] f3);
        logic [31:0] w = rd_ref(a[31:2]);
        logic [7:0]  b = 8'(w >> (8 * a[1:0]));
        logic [15:0] h = 16'(w >> (16 * a[1]));
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return {24'b0, b};
            3'd1:    return 32'($signed(h));
            3'd5:    return {16'b0, h};
            default: return w;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < SETS; i++) resident[i] = -1;
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    // One CPU access: predict the response, drive it, hold it until the cache stops stalling.
    task automatic do_op(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                         input logic [2:0] f3, output int st);
        logic [29:0] w;
        logic [31:0] old;
        wr_t         e;
        int          ix;
        logic        hit, done;
        w   = a[31:2];
        ix  = int'(w % SETS);
        hit = 0;
        if (we) begin
            e.addr  = {w, 2'b00};
            e.strb  = f3 == 3'd0 ? 4'(1 << a[1:0]) : f3 == 3'd1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
            e.wdata = f3 == 3'd0 ? {4{wd[7:0]}} : f3 == 3'd1 ? {2{wd[15:0]}} : wd;
            wr_q.push_back(e);
            old = rd_ref(w);
            for (int i = 0; i < 4; i++) if (e.strb[i]) old[8*i +: 8] = e.wdata[8*i +: 8];
            ref_mem[w] = old;
        end else if (re) begin
            hit = resident[ix] == int'(w);
            rd_q.push_back(ld_val(a, f3));
            exp_hit++;
            if (!hit) begin
                exp_miss++;
                resident[ix] = int'(w);
            end
        end
        @(posedge clk); #1;
        A = a; WD = wd; WE = we; RE = re; AddressingControl = f3;
        st = 0;
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (!Stall) done = 1; else st++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: access %h still stalled after 50 cycles", a);
        end
        @(posedge clk); #1;
        WE = 0; RE = 0;
        if (re && !we) check("hit_no_stall", 32'(st == 0), 32'(hit));
        if (we) check("store_stalls", 32'(st > 0), 32'd1);
        check("hit_count", HitCount, exp_hit);
        check("miss_count", MissCount, exp_miss);
    endtask

    task automatic flush_op();
        @(posedge clk); #1;
        Flush = 1;
        @(negedge clk);
        check("flush_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        Flush = 0;
        for (int i = 0; i < SETS; i++) resident[i] = -1;
    endtask

    // Monitor: every load the CPU retires must match the oldest predicted load value.
    initial forever begin
        @(negedge clk);
        if (rst && RE && !WE && !Stall) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %h expected no load", RD);
            end else check("rd", RD, rd_q.pop_front());
        end
    end

    // Main memory: random-latency ack, checks each write beat against the store queue.
    initial begin
        mem_ack   = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 0;
            if (!rst || !mem_req) lat = -1;
            else begin
                if (lat < 0) lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
                if (lat == 0) begin
                    mem_ack = 1;
                    lat = -1;
                    if (mem_we) begin
                        if (wr_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL wr_unexpected: got addr %h expected no write", mem_addr);
                        end else begin
                            wr_t e;
                            logic [31:0] old;
                            e = wr_q.pop_front();
                            check("wr_addr", mem_addr, e.addr);
                            check("wr_data", mem_wdata, e.wdata);
                            check("wr_strb", 32'(mem_wstrb), 32'(e.strb));
                            old = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : init_word(mem_addr[31:2]);
                            for (int i = 0; i < 4; i++) if (mem_wstrb[i]) old[8*i +: 8] = mem_wdata[8*i +: 8];
                            mem[mem_addr[31:2]] = old;
                        end
                    end else begin
                        check("rd_strb", 32'(mem_wstrb), 32'd0);
                        mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : init_word(mem_addr[31:2]);
                    end
                end else lat--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bases [4];
        logic [2:0]  f3s [7];
        logic [31:0] a;
        logic [2:0]  f;
        int          r;
        bases = '{32'h000, 32'h040, 32'h100, 32'h200};
        f3s   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
        rst = 0; A = 0; WD = 0; WE = 0; RE = 0; Flush = 0; AddressingControl = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit", HitCount, 0);
        check("rst_miss", MissCount, 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_rd", RD, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1;
        mem[30'h40] = 32'hDEADBEEF;
        ref_mem[30'h40] = 32'hDEADBEEF;

        fixed_lat = 2;
        do_op(32'h100, 0, 0, 1, 3'd2, stalls);
        check("miss_stall_cycles", stalls, 4);
        do_op(32'h100, 0, 0, 1, 3'd2, stalls);
        fixed_lat = 1;
        do_op(32'h101, 32'h7F, 1, 0, 3'd0, stalls);
        check("store_stall_cycles", stalls, 2);
        do_op(32'h100, 0, 0, 1, 3'd2, stalls);
        do_op(32'h103, 0, 0, 1, 3'd0, stalls);
        do_op(32'h103, 0, 0, 1, 3'd4, stalls);
        do_op(32'h102, 0, 0, 1, 3'd1, stalls);
        fixed_lat = -1;
        do_op(32'h200, 32'h1234_5678, 1, 0, 3'd2, stalls);
        do_op(32'h200, 0, 0, 1, 3'd2, stalls);
        do_op(32'h000, 0, 0, 1, 3'd2, stalls);
        do_op(32'h040, 0, 0, 1, 3'd2, stalls);
        do_op(32'h000, 0, 0, 1, 3'd2, stalls);

        // Abort a fill with reset; the line must not become valid.
        fixed_lat = 3;
        @(posedge clk); #1;
        A = 32'h300; RE = 1; AddressingControl = 3'd2;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("abort_req", 32'(mem_req), 0);
        check("abort_stall", 32'(Stall), 0);
        check("abort_rd", RD, 0);
        RE = 0;
        reset_model();
        @(negedge clk);
        rst = 1;
        fixed_lat = -1;
        do_op(32'h300, 0, 0, 1, 3'd2, stalls);
        do_op(32'h300, 0, 0, 1, 3'd2, stalls);
        flush_op();
        do_op(32'h300, 0, 0, 1, 3'd2, stalls);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            f = f3s[$urandom_range(0, 6)];
            if (r == 0) flush_op();
            else if (r < 4) do_op(a, $urandom, 1, 0, f, stalls);
            else do_op(a, 0, 0, 1, f, stalls);
        end
        repeat (3) @(posedge clk);
        check("rd_queue_empty", 32'(rd_q.size()), 0);
        check("wr_queue_empty", 32'(wr_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
